// File: rtl/term_console_core.sv
// Text console core: ROWS x COLS character grid with circular-scroll addressing,
// command-line editor, committed-line streamer and program-output printer.
module term_console_core #(
    parameter int unsigned COLS       = 70,
    parameter int unsigned ROWS       = 60,
    parameter int unsigned PROMPT_LEN = 9,
    parameter int unsigned LINE_MAX   = 128
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    key_valid,
    input  logic [7:0]              key_char,
    input  logic                    key_bs,
    input  logic                    key_enter,
    output logic                    key_ready,
    output logic                    line_valid,
    output logic [7:0]              line_char,
    output logic                    line_last,
    input  logic                    line_ready,
    input  logic                    prog_valid,
    input  logic [7:0]              prog_char,
    output logic                    prog_ready,
    input  logic                    done_in,
    output logic                    done_out,
    input  logic [$clog2(ROWS)-1:0] rd_row,
    input  logic [$clog2(COLS)-1:0] rd_col,
    output logic [7:0]              rd_char,
    output logic                    rd_prompt,
    output logic [$clog2(ROWS)-1:0] cur_row,
    output logic [$clog2(COLS)-1:0] cur_col
);

    localparam int unsigned RW     = $clog2(ROWS);
    localparam int unsigned CW     = $clog2(COLS);
    localparam int unsigned CELLS  = ROWS * COLS;
    localparam int unsigned AW     = $clog2(CELLS);
    localparam int unsigned LW     = $clog2(LINE_MAX + 1);
    localparam int unsigned LDEPTH = 1 << LW;

    typedef enum logic [2:0] {
        S_CLEAR_ALL,
        S_EDIT,
        S_CLEAR_ROW,
        S_SEND,
        S_RUN,
        S_PROMPT
    } state_e;

    logic [7:0] grid_mem [CELLS];
    logic [7:0] line_buf [LDEPTH];

    state_e          state_q, state_d, ret_q, ret_d, nr_ret;
    logic [RW-1:0]   top_q, top_d, cur_row_q, cur_row_d, bs_row;
    logic [CW-1:0]   cur_col_q, cur_col_d, bs_col;
    logic [ROWS-1:0] prompt_flag_q, prompt_flag_d;
    logic [LW-1:0]   line_len_q, line_len_d, idx_q, idx_d;
    logic [AW-1:0]   clr_q, clr_d;
    logic            done_pend_q, done_pend_d;
    logic            key_ready_q, key_ready_d, prog_ready_q, prog_ready_d;
    logic            line_valid_q, line_valid_d, line_last_q, line_last_d;
    logic [7:0]      line_char_q, line_char_d, rd_char_q, rd_char_d;
    logic            done_out_q, done_out_d, rd_prompt_q, rd_prompt_d;

    logic            g_we, l_we, do_newrow, place_prompt, load_beat;
    logic [AW-1:0]   g_addr, rd_addr;
    logic [7:0]      g_wdata, l_wdata;
    logic [LW-1:0]   l_addr;

    // Logical (row, col) to flat cell index through the circular top-row pointer.
    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] top,
                                                input logic [RW-1:0] lrow,
                                                input logic [CW-1:0] col);
        logic [RW:0] sum;
        logic [RW:0] prow;
        sum  = {1'b0, top} + {1'b0, lrow};
        prow = (sum >= (RW+1)'(ROWS)) ? sum - (RW+1)'(ROWS) : sum;
        return AW'(prow) * AW'(COLS) + AW'(col);
    endfunction

    assign rd_addr = cell_addr(top_q, rd_row, rd_col);

    always_comb begin
        state_d       = state_q;
        ret_d         = ret_q;
        top_d         = top_q;
        cur_row_d     = cur_row_q;
        cur_col_d     = cur_col_q;
        prompt_flag_d = prompt_flag_q;
        line_len_d    = line_len_q;
        idx_d         = idx_q;
        clr_d         = clr_q;
        done_pend_d   = done_pend_q | done_in;
        line_valid_d  = line_valid_q;
        line_char_d   = line_char_q;
        line_last_d   = line_last_q;
        done_out_d    = 1'b0;
        g_we          = 1'b0;
        g_addr        = cell_addr(top_q, cur_row_q, cur_col_q);
        g_wdata       = 8'h00;
        l_we          = 1'b0;
        l_addr        = line_len_q;
        l_wdata       = key_char;
        do_newrow     = 1'b0;
        nr_ret        = S_EDIT;
        place_prompt  = 1'b0;
        load_beat     = 1'b0;
        bs_row        = cur_row_q;
        bs_col        = cur_col_q;

        case (state_q)
            S_CLEAR_ALL: begin
                g_we   = 1'b1;
                g_addr = clr_q;
                if (clr_q == AW'(CELLS - 1)) begin
                    clr_d   = '0;
                    state_d = S_EDIT;
                end else begin
                    clr_d = clr_q + AW'(1);
                end
            end
            S_CLEAR_ROW: begin
                g_we   = 1'b1;
                g_addr = cell_addr(top_q, cur_row_q, CW'(clr_q));
                if (clr_q == AW'(COLS - 1)) begin
                    clr_d   = '0;
                    state_d = ret_q;
                end else begin
                    clr_d = clr_q + AW'(1);
                end
            end
            S_EDIT: begin
                if (key_valid && key_ready_q) begin
                    if (key_enter) begin
                        do_newrow = 1'b1;
                        nr_ret    = S_SEND;
                    end else if (key_bs) begin
                        if (line_len_q != '0) begin
                            if (cur_col_q == '0) begin
                                bs_col = CW'(COLS - 1);
                                bs_row = (cur_row_q == '0) ? RW'(ROWS - 1) : cur_row_q - RW'(1);
                            end else begin
                                bs_col = cur_col_q - CW'(1);
                            end
                            cur_row_d  = bs_row;
                            cur_col_d  = bs_col;
                            g_we       = 1'b1;
                            g_addr     = cell_addr(top_q, bs_row, bs_col);
                            line_len_d = line_len_q - LW'(1);
                        end
                    end else if (line_len_q != LW'(LINE_MAX)) begin
                        g_we       = 1'b1;
                        g_wdata    = key_char;
                        l_we       = 1'b1;
                        line_len_d = line_len_q + LW'(1);
                        if (cur_col_q == CW'(COLS - 1)) begin
                            do_newrow = 1'b1;
                            nr_ret    = S_EDIT;
                        end else begin
                            cur_col_d = cur_col_q + CW'(1);
                        end
                    end
                end
            end
            S_SEND: begin
                if (line_valid_q && line_ready) begin
                    if (line_last_q) begin
                        line_valid_d = 1'b0;
                        line_last_d  = 1'b0;
                        line_char_d  = 8'h00;
                        line_len_d   = '0;
                        state_d      = S_RUN;
                    end else begin
                        idx_d     = idx_q + LW'(1);
                        load_beat = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // A program beat always goes first; a coinciding done waits in done_pend.
                if (prog_valid && prog_ready_q) begin
                    if (prog_char == 8'h00) begin
                        do_newrow = 1'b1;
                        nr_ret    = S_RUN;
                    end else begin
                        g_we    = 1'b1;
                        g_wdata = prog_char;
                        if (cur_col_q == CW'(COLS - 1)) begin
                            do_newrow = 1'b1;
                            nr_ret    = S_RUN;
                        end else begin
                            cur_col_d = cur_col_q + CW'(1);
                        end
                    end
                end else if (done_pend_q || done_in) begin
                    done_pend_d = 1'b0;
                    if (cur_col_q != '0) begin
                        do_newrow = 1'b1;
                        nr_ret    = S_PROMPT;
                    end else begin
                        place_prompt = 1'b1;
                    end
                end
            end
            S_PROMPT: place_prompt = 1'b1;
            default:  state_d = S_CLEAR_ALL;
        endcase

        // Next row: step down, or scroll by moving top and clearing the new bottom row.
        if (do_newrow) begin
            cur_col_d = '0;
            if (cur_row_q != RW'(ROWS - 1)) begin
                cur_row_d = cur_row_q + RW'(1);
                state_d   = nr_ret;
            end else begin
                top_d         = (top_q == RW'(ROWS - 1)) ? '0 : top_q + RW'(1);
                prompt_flag_d = prompt_flag_q >> 1;
                clr_d         = '0;
                ret_d         = nr_ret;
                state_d       = S_CLEAR_ROW;
            end
        end

        if (place_prompt) begin
            prompt_flag_d[cur_row_q] = 1'b1;
            cur_col_d                = CW'(PROMPT_LEN);
            done_out_d               = 1'b1;
            state_d                  = S_EDIT;
        end

        if (state_d == S_SEND && state_q != S_SEND) begin
            idx_d     = '0;
            load_beat = 1'b1;
        end
        if (load_beat) begin
            line_valid_d = 1'b1;
            line_char_d  = (idx_d < line_len_q) ? line_buf[idx_d] : 8'h00;
            line_last_d  = (idx_d == line_len_q);
        end

        key_ready_d  = (state_d == S_EDIT);
        prog_ready_d = (state_d == S_RUN);
        rd_char_d    = grid_mem[rd_addr];
        rd_prompt_d  = prompt_flag_q[rd_row] && (rd_col < CW'(PROMPT_LEN));
    end

    always_ff @(posedge clk) begin
        if (g_we) grid_mem[g_addr] <= g_wdata;
        if (l_we) line_buf[l_addr] <= l_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_CLEAR_ALL;
            ret_q         <= S_EDIT;
            top_q         <= '0;
            cur_row_q     <= '0;
            cur_col_q     <= CW'(PROMPT_LEN);
            prompt_flag_q <= ROWS'(1);
            line_len_q    <= '0;
            idx_q         <= '0;
            clr_q         <= '0;
            done_pend_q   <= 1'b0;
            key_ready_q   <= 1'b0;
            prog_ready_q  <= 1'b0;
            line_valid_q  <= 1'b0;
            line_char_q   <= 8'h00;
            line_last_q   <= 1'b0;
            done_out_q    <= 1'b0;
            rd_char_q     <= 8'h00;
            rd_prompt_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ret_q         <= ret_d;
            top_q         <= top_d;
            cur_row_q     <= cur_row_d;
            cur_col_q     <= cur_col_d;
            prompt_flag_q <= prompt_flag_d;
            line_len_q    <= line_len_d;
            idx_q         <= idx_d;
            clr_q         <= clr_d;
            done_pend_q   <= done_pend_d;
            key_ready_q   <= key_ready_d;
            prog_ready_q  <= prog_ready_d;
            line_valid_q  <= line_valid_d;
            line_char_q   <= line_char_d;
            line_last_q   <= line_last_d;
            done_out_q    <= done_out_d;
            rd_char_q     <= rd_char_d;
            rd_prompt_q   <= rd_prompt_d;
        end
    end

    assign key_ready  = key_ready_q;
    assign prog_ready = prog_ready_q;
    assign line_valid = line_valid_q;
    assign line_char  = line_char_q;
    assign line_last  = line_last_q;
    assign done_out   = done_out_q;
    assign rd_char    = rd_char_q;
    assign rd_prompt  = rd_prompt_q;
    assign cur_row    = cur_row_q;
    assign cur_col    = cur_col_q;

endmodule

// File: tb/tb_term_console_core.sv
// Bench for term_console_core on an 8x4 grid: committed-line beats are checked by
// a queue-based scoreboard; grid, cursor and handshake state by directed checks.
module tb_term_console_core;

    localparam int unsigned COLS = 8;
    localparam int unsigned ROWS = 4;
    localparam int unsigned PL   = 2;
    localparam int unsigned LM   = 10;
    localparam int unsigned RW   = $clog2(ROWS);
    localparam int unsigned CW   = $clog2(COLS);

    typedef struct packed {
        logic [7:0] ch;
        logic       last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          key_valid, key_bs, key_enter, key_ready;
    logic [7:0]    key_char;
    logic          line_valid, line_last, line_ready;
    logic [7:0]    line_char;
    logic          prog_valid, prog_ready, done_in, done_out;
    logic [7:0]    prog_char;
    logic [RW-1:0] rd_row, cur_row;
    logic [CW-1:0] rd_col, cur_col;
    logic [7:0]    rd_char;
    logic          rd_prompt;

    int    checks = 0;
    int    failures = 0;
    int    done_pulses = 0;
    int    done_run = 0;
    beat_t exp_q[$];
    logic       hold_pend = 1'b0;
    logic [7:0] hold_ch;
    logic       hold_last;

    always #5 clk = ~clk;

    term_console_core #(.COLS(COLS), .ROWS(ROWS), .PROMPT_LEN(PL), .LINE_MAX(LM)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_valid(key_valid), .key_char(key_char), .key_bs(key_bs),
        .key_enter(key_enter), .key_ready(key_ready),
        .line_valid(line_valid), .line_char(line_char), .line_last(line_last),
        .line_ready(line_ready),
        .prog_valid(prog_valid), .prog_char(prog_char), .prog_ready(prog_ready),
        .done_in(done_in), .done_out(done_out),
        .rd_row(rd_row), .rd_col(rd_col), .rd_char(rd_char), .rd_prompt(rd_prompt),
        .cur_row(cur_row), .cur_col(cur_col)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pops on every accepted beat, and checks hold stability.
    initial begin : monitor
        beat_t b;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_pend = 1'b0;
                done_run  = 0;
            end else begin
                if (hold_pend) begin
                    check("hold_valid", int'(line_valid), 1);
                    check("hold_char", int'(line_char), int'(hold_ch));
                    check("hold_last", int'(line_last), int'(hold_last));
                end
                hold_pend = line_valid && !line_ready;
                hold_ch   = line_char;
                hold_last = line_last;
                if (line_valid && line_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL beat_unexpected: got char 0x%0h last %0d", line_char, line_last);
                    end else begin
                        b = exp_q.pop_front();
                        check("beat_char", int'(line_char), int'(b.ch));
                        check("beat_last", int'(line_last), int'(b.last));
                    end
                end
                if (done_out) begin
                    done_run++;
                end else if (done_run != 0) begin
                    check("done_out_width", done_run, 1);
                    done_pulses++;
                    done_run = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_reset();
        check("rst_key_ready", int'(key_ready), 0);
        check("rst_prog_ready", int'(prog_ready), 0);
        check("rst_line_valid", int'(line_valid), 0);
        check("rst_done_out", int'(done_out), 0);
        check("rst_rd_char", int'(rd_char), 0);
        check("rst_rd_prompt", int'(rd_prompt), 0);
        check("rst_cur_row", int'(cur_row), 0);
        check("rst_cur_col", int'(cur_col), int'(PL));
    endtask

    task automatic do_reset();
        key_valid = 1'b0; key_bs = 1'b0; key_enter = 1'b0; key_char = 8'h00;
        prog_valid = 1'b0; prog_char = 8'h00; done_in = 1'b0; line_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset();
        tick();
        rst_n = 1'b1;
        repeat (31) tick();
        check("clear_all_busy", int'(key_ready), 0);
        tick();
        check("clear_all_done", int'(key_ready), 1);
    endtask

    task automatic send_key(input logic [7:0] c, input logic bs, input logic en);
        int n = 0;
        while (!key_ready && n < 100) begin tick(); n++; end
        check("key_ready_wait", int'(key_ready), 1);
        key_valid = 1'b1; key_char = c; key_bs = bs; key_enter = en;
        tick();
        key_valid = 1'b0; key_bs = 1'b0; key_enter = 1'b0;
    endtask

    task automatic type_str(input string s);
        for (int i = 0; i < s.len(); i++) send_key(s[i], 1'b0, 1'b0);
    endtask

    task automatic send_prog(input logic [7:0] c, input logic d);
        int n = 0;
        while (!prog_ready && n < 100) begin tick(); n++; end
        check("prog_ready_wait", int'(prog_ready), 1);
        prog_valid = 1'b1; prog_char = c; done_in = d;
        tick();
        prog_valid = 1'b0; done_in = 1'b0;
    endtask

    task automatic push_line(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back('{ch: s[i], last: 1'b0});
        exp_q.push_back('{ch: 8'h00, last: 1'b1});
    endtask

    task automatic wait_line_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
        check("line_drain", exp_q.size(), 0);
        tick();
    endtask

    task automatic check_cell(input string name, input int r, input int c, input int exp_ch);
        rd_row = RW'(r); rd_col = CW'(c);
        tick();
        check(name, int'(rd_char), exp_ch);
    endtask

    task automatic check_prompt(input string name, input int r, input int c, input int exp_p);
        rd_row = RW'(r); rd_col = CW'(c);
        tick();
        check(name, int'(rd_prompt), exp_p);
    endtask

    task automatic check_cur(input string name, input int r, input int c);
        check({name, "_row"}, int'(cur_row), r);
        check({name, "_col"}, int'(cur_col), c);
    endtask

    initial begin : main
        int n;
        rd_row = '0; rd_col = '0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic command: "ab" + Enter, then done places a prompt on row 1.
        do_reset();
        check_prompt("prompt_row0", 0, 0, 1);
        check_prompt("prompt_row0_text", 0, 2, 0);
        push_line("ab");
        type_str("ab");
        send_key(8'h00, 1'b0, 1'b1);
        wait_line_done();
        check("run_prog_ready", int'(prog_ready), 1);
        check("run_key_ready", int'(key_ready), 0);
        check_cur("after_enter", 1, 0);
        check_cell("cell_a", 0, 2, 8'h61);
        check_cell("cell_b", 0, 3, 8'h62);
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        check("done_pulse_hi", int'(done_out), 1);
        check_cur("prompt1", 1, 2);
        tick();
        check("done_pulse_lo", int'(done_out), 0);
        check_prompt("prompt_row1", 1, 1, 1);
        check_prompt("prompt_row1_text", 1, 2, 0);

        // Wrap to the next row, then backspace back across the row boundary.
        do_reset();
        type_str("1234567");
        check_cur("wrap", 1, 1);
        check_cell("cell_7", 1, 0, 8'h37);
        send_key(8'h00, 1'b1, 1'b0);
        send_key(8'h00, 1'b1, 1'b0);
        check_cur("bs_back", 0, 7);
        check_cell("bs_cleared", 0, 7, 0);
        check_cell("bs_kept", 0, 6, 8'h35);
        push_line("12345");
        send_key(8'h00, 1'b0, 1'b1);
        wait_line_done();
        check_cur("enter2", 1, 0);

        // Overlong line with a stalled executor; Enter together with backspace.
        do_reset();
        type_str("ABCDEFGHIJKL");
        check_cur("full", 1, 4);
        check_cell("last_stored", 1, 3, 8'h4A);
        check_cell("dropped", 1, 4, 0);
        line_ready = 1'b0;
        push_line("ABCDEFGHIJ");
        send_key(8'h00, 1'b1, 1'b1);
        repeat (5) tick();
        check("stall_valid", int'(line_valid), 1);
        check("stall_char", int'(line_char), 8'h41);
        line_ready = 1'b1;
        repeat (3) tick();
        line_ready = 1'b0;
        repeat (5) tick();
        check("stall2_char", int'(line_char), 8'h44);
        line_ready = 1'b1;
        wait_line_done();
        check_cur("enter3", 2, 0);

        // Program output reaching the bottom row scrolls by one.
        send_prog(8'h00, 1'b0);
        send_prog(8'h78, 1'b0);
        check_cur("prog_x", 3, 1);
        send_prog(8'h00, 1'b0);
        n = 0;
        while (!prog_ready && n < 50) begin tick(); n++; end
        check("clear_row_cycles", n, 8);
        check_cur("scrolled", 3, 0);
        check_cell("scroll_x", 2, 0, 8'h78);
        check_cell("scroll_g", 0, 0, 8'h47);
        check_prompt("scroll_prompt_gone", 0, 0, 0);
        check_cell("new_bottom_clear", 3, 2, 0);

        // done_in coinciding with a program beat.
        send_prog(8'h71, 1'b1);
        n = 0;
        while (!done_out && n < 100) begin tick(); n++; end
        check("done_seen", int'(done_out), 1);
        check_cur("prompt6", 3, 2);
        tick();
        check("done6_lo", int'(done_out), 0);
        check_cell("q_written", 2, 0, 8'h71);
        check_cell("x_moved", 1, 0, 8'h78);
        check_prompt("prompt_row3", 3, 0, 1);
        check_prompt("prompt_row3_text", 3, 2, 0);
        check_prompt("prompt_row2", 2, 0, 0);

        // Reset in the middle of a row clear.
        type_str("uvwxyz");
        check("clear_row_key_ready", int'(key_ready), 0);
        rd_row = RW'(1); rd_col = CW'(0);
        tick();
        check("pre_reset_rd", int'(rd_char), 8'h71);
        do_reset();

        check("line_queue_empty", exp_q.size(), 0);
        check("done_pulses", done_pulses, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/term_console_core.md
Name: term_console_core

Overview:
- Parametrised successor of the bash text console. Stores a ROWS x COLS ASCII character grid, edits the current command line from keyboard events, and streams the committed line to the command executor.
- Prints program output back onto the grid.
- Scrolls in O(1) with a circular top-row pointer plus a single-row clear, instead of copying the whole screen.
- Sits between the keyboard handler, the command executor and the VGA glyph renderer.

Parameters:
- COLS, 70, characters per row (>=4).
- ROWS, 60, rows in the grid (>=2).
- PROMPT_LEN, 9, prompt cells at the start of a prompt row (< COLS).
- LINE_MAX, 128, maximum editable command length in characters (< COLS*(ROWS-1)).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  one-cycle key event strobe.
- key_char  in  8  printable ASCII, valid with key_valid.
- key_bs  in  1  event is backspace; overrides key_char.
- key_enter  in  1  event is enter; overrides key_char.
- key_ready  out  1  key events are accepted only when key_valid and key_ready are both 1.
- line_valid  out  1  committed-line beat valid.
- line_char  out  8  committed-line character; 0 on the final beat.
- line_last  out  1  final beat of the line.
- line_ready  in  1  executor accepts the beat.
- prog_valid  in  1  program output character valid.
- prog_char  in  8  program output character; 0 means newline.
- prog_ready  out  1  program output handshake.
- done_in  in  1  one-cycle pulse: program finished.
- done_out  out  1  one-cycle pulse: new prompt row placed.
- rd_row  in  $clog2(ROWS)  logical display row, 0 = top.
- rd_col  in  $clog2(COLS)  display column.
- rd_char  out  8  character at (rd_row, rd_col); 1-cycle latency.
- rd_prompt  out  1  1 if the cell is a prompt cell; same latency as rd_char.
- cur_row  out  $clog2(ROWS)  cursor logical row.
- cur_col  out  $clog2(COLS)  cursor column.

Behaviour:
- Addressing:
  - Physical row = (top + logical row) mod ROWS.
  - Cell index = physical row * COLS + col.
  - All additions wrap modulo ROWS or COLS exactly.
- Reset (async, rst_n = 0):
  - State CLEAR_ALL; top = 0.
  - cur_row = 0, cur_col = PROMPT_LEN.
  - prompt_flag = only row 0.
  - line_len = 0.
  - Outputs: line_valid = 0, prog_ready = 0, key_ready = 0, done_out = 0, rd_char = 0, rd_prompt = 0.
- CLEAR_ALL: writes 0 to one cell per cycle, ROWS*COLS cycles, then goes to EDIT. Reset asserted mid-clear restarts the clear.
- EDIT (key_ready = 1):
  - Printable key:
    - If line_len = LINE_MAX, the key is dropped and nothing changes.
    - Otherwise write the cell at the cursor, store the character in line_buf[line_len], increment line_len, and advance the cursor.
    - Advancing from col COLS-1 goes to col 0 of the next row, via NEWROW.
  - Backspace:
    - Ignored when line_len = 0.
    - Otherwise move the cursor back one cell (col 0 goes to col COLS-1 of the previous row), write 0 there, and decrement line_len.
  - Enter: cursor moves to col 0 of the next row (NEWROW), then state SEND.
  - Simultaneous key_bs and key_enter: enter wins.
- NEWROW:
  - If cur_row < ROWS-1: cur_row + 1, single cycle.
  - Otherwise scroll: top = top + 1 mod ROWS, cur_row stays ROWS-1, prompt_flag is rotated so logical rows are preserved and the new bottom row flag is 0, then CLEAR_ROW.
  - CLEAR_ROW zeroes COLS cells of the new bottom row, one per cycle. key_ready and prog_ready are 0 throughout, then the state returns to its caller.
- SEND:
  - Beats line_buf[0 .. line_len-1], then a terminator beat with char 0 and line_last = 1.
  - An empty line sends the terminator only.
  - A beat advances only on line_valid and line_ready.
  - line_char and line_last are held stable while line_valid = 1 and line_ready = 0.
  - After the terminator is accepted: line_len = 0, state RUN.
- RUN (prog_ready = 1 outside clears):
  - A nonzero prog_char is written like a printable key, without touching line_buf.
  - prog_char 0 performs a NEWROW.
  - done_in:
    - If cur_col != 0, perform a NEWROW first.
    - Then set prompt_flag of cur_row, cur_col = PROMPT_LEN, pulse done_out for 1 cycle, state EDIT.
    - If done_in coincides with a prog beat, the beat is processed first and done is deferred one cycle; done_in is latched and never lost.
- Read port:
  - Reads are registered and independent of all states, including clears.
  - rd_prompt = prompt_flag[rd_row] && rd_col < PROMPT_LEN.

Test Plan:
1. Parameters COLS = 8, ROWS = 4, PROMPT_LEN = 2. Release reset, wait 32 cycles, then type "ab" and Enter -> cells (0,2) = 'a', (0,3) = 'b'; beats 'a', 'b', then 0 with last = 1; cur = (1,0); state RUN.
2. Type 7 characters from (0,2) -> the 7th lands at (1,0). Then 2 backspaces -> cur = (0,7), cell (0,7) = 0, line_len = 5.
3. LINE_MAX = 10; type 12 characters -> only 10 stored; the SEND stream has 11 beats; the last 2 keys leave the grid unchanged.
4. From cur_row = 3, stream prog chars 'x', 0 -> top = 1; row 3 cleared in 8 cycles with prog_ready = 0; rd(2, 0) returns 'x'.
5. Hold line_ready = 0 for 5 cycles mid-SEND -> line_char is stable and no beat is skipped.
6. Assert done_in together with a prog beat 'q' -> 'q' is written, then a new prompt row, cur_col = 2, done_out = 1 for exactly 1 cycle. Assert rst_n low mid-CLEAR_ROW -> all outputs return to reset values.
